// File: rtl/key_matrix_scanner_pkg.sv
// Shared definitions for the key matrix scanner: event byte layout and
// the scan FSM state encoding.
package key_matrix_scanner_pkg;

    // Event byte layout: bit 7 is the new key state (1 = press), bits 6:0 the key index.
    localparam int EV_PRESS_BIT = 7;
    localparam int EV_KEY_MSB   = 6;

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        SAMPLE,
        EVAL,
        EMIT,
        GAP
    } scan_state_t;

endpackage

// File: rtl/key_matrix_scanner_sync_2ff.sv
// Width-parameterized two-flop synchronizer for asynchronous inputs.
module sync_2ff #(
    parameter int WIDTH   = 1,
    parameter bit RST_VAL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q, meta_d;
    logic [WIDTH-1:0] sync_q, sync_d;

    // Next values for the two synchronizer stages.
    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    // Two back-to-back flops; the first may go metastable, the second resolves it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= {WIDTH{RST_VAL}};
            sync_q <= {WIDTH{RST_VAL}};
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/key_matrix_scanner.sv
// Key matrix scanner: drives one active-low row at a time, samples the
// synchronized columns, debounces every key with a 2-bit counter and emits
// one press/release byte per debounced change as a 2-cycle write strobe.
module key_matrix_scanner
    import key_matrix_scanner_pkg::*;
#(
    parameter int ROWS           = 4,
    parameter int COLS           = 4,
    parameter int SCAN_DIV       = 1000,
    parameter int SETTLE_CYC     = 4,
    parameter int DEBOUNCE_SCANS = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ScanEn,
    output logic [ROWS-1:0]      Row,
    input  logic [COLS-1:0]      Col,
    output logic [7:0]           EvData,
    output logic                 EvWr,
    output logic [ROWS*COLS-1:0] KeysDown,
    output logic                 Busy
);

    localparam int NKEYS = ROWS * COLS;
    localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW    = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int KW    = (NKEYS > 1) ? $clog2(NKEYS) : 1;
    localparam int TW    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int SW    = $clog2(SETTLE_CYC);

    localparam logic [RW-1:0] LAST_ROW    = RW'(ROWS - 1);
    localparam logic [CW-1:0] LAST_COL    = CW'(COLS - 1);
    localparam logic [TW-1:0] LAST_TICK   = TW'(SCAN_DIV - 1);
    localparam logic [SW-1:0] LAST_SETTLE = SW'(SETTLE_CYC - 1);
    localparam logic [2:0]    DEB_TARGET  = 3'(DEBOUNCE_SCANS);

    logic [COLS-1:0] col_sync;

    logic [TW-1:0]             tick_cnt_q, tick_cnt_d;
    logic                      tick;
    scan_state_t               state_q, state_d;
    logic [RW-1:0]             row_q, row_d;
    logic [CW-1:0]             col_q, col_d;
    logic [SW-1:0]             settle_q, settle_d;
    logic                      phase_q, phase_d;
    logic [COLS-1:0]           raw_q, raw_d;
    logic [NKEYS-1:0]          keys_q, keys_d;
    logic [NKEYS-1:0][1:0]     cnt_q, cnt_d;
    logic [ROWS-1:0]           row_drv_q, row_drv_d;
    logic [7:0]                ev_data_q, ev_data_d;
    logic                      ev_wr_q, ev_wr_d;

    logic [KW-1:0]             key_idx;
    logic [2:0]                cnt_inc;
    logic                      advance;

    // Columns idle high, so the synchronizer resets to "no key".
    sync_2ff #(
        .WIDTH   (COLS),
        .RST_VAL (1'b1)
    ) u_col_sync (
        .clk (clk),
        .rst (rst),
        .d   (Col),
        .q   (col_sync)
    );

    // Free-running frame-start divider; tick is high on the wrap cycle.
    always_comb begin
        tick       = (tick_cnt_q == LAST_TICK);
        tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    end

    // Scan FSM next-state, debounce update and event formation.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        settle_d  = settle_q;
        phase_d   = phase_q;
        raw_d     = raw_q;
        keys_d    = keys_q;
        cnt_d     = cnt_q;
        row_drv_d = row_drv_q;
        ev_data_d = ev_data_q;
        ev_wr_d   = ev_wr_q;
        advance   = 1'b0;
        key_idx   = KW'(row_q * COLS + col_q);
        cnt_inc   = {1'b0, cnt_q[key_idx]} + 3'd1;

        case (state_q)
            IDLE: begin
                if (tick && ScanEn) begin
                    state_d   = DRIVE;
                    row_d     = '0;
                    settle_d  = '0;
                    row_drv_d = ~ROWS'(1);
                end
            end
            DRIVE: begin
                if (settle_q == LAST_SETTLE) begin
                    state_d = SAMPLE;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            SAMPLE: begin
                raw_d   = ~col_sync;
                col_d   = '0;
                state_d = EVAL;
            end
            EVAL: begin
                if (raw_q[col_q] == keys_q[key_idx]) begin
                    cnt_d[key_idx] = 2'd0;
                    advance        = 1'b1;
                end else if (cnt_inc == DEB_TARGET) begin
                    keys_d[key_idx]              = ~keys_q[key_idx];
                    cnt_d[key_idx]               = 2'd0;
                    ev_data_d[EV_PRESS_BIT]      = ~keys_q[key_idx];
                    ev_data_d[EV_KEY_MSB:0]      = 7'(key_idx);
                    ev_wr_d                      = 1'b1;
                    phase_d                      = 1'b0;
                    state_d                      = EMIT;
                end else begin
                    cnt_d[key_idx] = cnt_inc[1:0];
                    advance        = 1'b1;
                end
            end
            EMIT: begin
                if (phase_q) begin
                    ev_wr_d = 1'b0;
                    phase_d = 1'b0;
                    state_d = GAP;
                end else begin
                    phase_d = 1'b1;
                end
            end
            GAP: begin
                if (phase_q) begin
                    phase_d = 1'b0;
                    advance = 1'b1;
                end else begin
                    phase_d = 1'b1;
                end
            end
            default: begin
                state_d   = IDLE;
                row_drv_d = '1;
            end
        endcase

        // Step to the next column, the next row, or finish the frame.
        if (advance) begin
            if (col_q != LAST_COL) begin
                col_d   = col_q + 1'b1;
                state_d = EVAL;
            end else if (row_q != LAST_ROW) begin
                row_d     = row_q + 1'b1;
                settle_d  = '0;
                row_drv_d = ~(ROWS'(1) << (row_q + 1'b1));
                state_d   = DRIVE;
            end else begin
                row_d     = '0;
                row_drv_d = '1;
                state_d   = IDLE;
            end
        end
    end

    // State registers; reset also kills an in-flight strobe with no retry.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: the per-key counters and key states are plain flops, not a RAM,
        // so they can and do take the reset value.
        if (rst) begin
            tick_cnt_q <= '0;
            state_q    <= IDLE;
            row_q      <= '0;
            col_q      <= '0;
            settle_q   <= '0;
            phase_q    <= 1'b0;
            raw_q      <= '0;
            keys_q     <= '0;
            cnt_q      <= '0;
            row_drv_q  <= '1;
            ev_data_q  <= '0;
            ev_wr_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            tick_cnt_q <= tick_cnt_d;
            state_q    <= state_d;
            row_q      <= row_d;
            col_q      <= col_d;
            settle_q   <= settle_d;
            phase_q    <= phase_d;
            raw_q      <= raw_d;
            keys_q     <= keys_d;
            cnt_q      <= cnt_d;
            row_drv_q  <= row_drv_d;
            ev_data_q  <= ev_data_d;
            ev_wr_q    <= ev_wr_d;
        end
    end

    assign Row      = row_drv_q;
    assign EvData   = ev_data_q;
    assign EvWr     = ev_wr_q;
    assign KeysDown = keys_q;
    assign Busy     = (state_q != IDLE);

endmodule

// File: tb/tb_key_matrix_scanner.sv
// Directed bench for key_matrix_scanner with a resistive matrix model and
// a FIFO model that captures on the rising edge of EvWr.
module tb_key_matrix_scanner;

    localparam int ROWS = 4;
    localparam int COLS = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        ScanEn;
    logic [3:0]  Row;
    logic [3:0]  Col;
    logic [7:0]  EvData;
    logic        EvWr;
    logic [15:0] KeysDown;
    logic        Busy;
    logic [15:0] pressed;

    int compared   = 0;
    int mismatched = 0;

    // FIFO model and strobe-shape bookkeeping.
    logic [7:0] fifo[$];
    int         wr_width[$];
    logic       prev_wr  = 1'b0;
    int         hi_run   = 0;
    int         lo_run   = 1000;
    int         last_gap = 0;
    logic [7:0] hold_ref = 8'h00;
    int         hold_cnt = 0;
    int         unstable = 0;

    always #5 clk = ~clk;

    key_matrix_scanner #(
        .ROWS           (4),
        .COLS           (4),
        .SCAN_DIV       (64),
        .SETTLE_CYC     (4),
        .DEBOUNCE_SCANS (3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ScanEn   (ScanEn),
        .Row      (Row),
        .Col      (Col),
        .EvData   (EvData),
        .EvWr     (EvWr),
        .KeysDown (KeysDown),
        .Busy     (Busy)
    );

    // Matrix model: a pressed key pulls its column low while its row is driven low.
    always_comb begin
        Col = '1;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (!Row[r] && pressed[r*COLS+c]) Col[c] = 1'b0;
    end

    // FIFO write detector sampled on the falling edge, away from DUT updates.
    always @(negedge clk) begin
        prev_wr <= EvWr;
        if (EvWr && !prev_wr) begin
            fifo.push_back(EvData);
            last_gap <= lo_run;
            hold_ref <= EvData;
            hold_cnt <= 3;
        end else if (hold_cnt > 0) begin
            if (EvData !== hold_ref) unstable <= unstable + 1;
            hold_cnt <= hold_cnt - 1;
        end
        if (EvWr) hi_run <= prev_wr ? hi_run + 1 : 1;
        else      lo_run <= prev_wr ? 1 : lo_run + 1;
        if (!EvWr && prev_wr) wr_width.push_back(hi_run);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Wait for one full frame (Busy rise then fall), bounded.
    task automatic wait_frame();
        logic seen;
        seen = 1'b0;
        for (int n = 0; n < 200 && !seen; n++) begin
            @(negedge clk);
            if (Busy) seen = 1'b1;
        end
        check("frame_start", seen, 1);
        seen = 1'b0;
        for (int n = 0; n < 200 && !seen; n++) begin
            @(negedge clk);
            if (!Busy) seen = 1'b1;
        end
        check("frame_end", seen, 1);
    endtask

    initial begin
        int  base;
        logic seen;

        rst     = 1'b1;
        ScanEn  = 1'b0;
        pressed = '0;
        repeat (3) @(negedge clk);

        // Reset state.
        check("rst_row",      Row,      4'hF);
        check("rst_evwr",     EvWr,     0);
        check("rst_evdata",   EvData,   8'h00);
        check("rst_keysdown", KeysDown, 16'h0000);
        check("rst_busy",     Busy,     0);
        rst = 1'b0;

        // ScanEn low: no frame ever starts.
        repeat (100) @(negedge clk);
        check("scanen_off_busy", Busy, 0);
        check("scanen_off_row",  Row,  4'hF);

        // One empty frame: no strobe.
        ScanEn = 1'b1;
        wait_frame();
        check("empty_fifo", fifo.size(), 0);
        check("empty_keys", KeysDown, 16'h0000);

        // Bounce: (1,2) pressed for two frames then released.
        pressed = 16'h0040;
        wait_frame();
        wait_frame();
        pressed = 16'h0000;
        wait_frame();
        wait_frame();
        wait_frame();
        check("bounce_fifo", fifo.size(), 0);
        check("bounce_keys", KeysDown, 16'h0000);

        // Press (1,2): silent for two frames (proves counter restarted at 0), event in frame 3.
        pressed = 16'h0040;
        wait_frame();
        check("press_f1_fifo", fifo.size(), 0);
        wait_frame();
        check("press_f2_fifo", fifo.size(), 0);
        check("press_f2_keys", KeysDown, 16'h0000);
        wait_frame();
        check("press_fifo_n",  fifo.size(), 1);
        check("press_data",    fifo[0], 8'h86);
        check("press_width",   wr_width[0], 2);
        check("press_keys",    KeysDown, 16'h0040);
        check("press_hold",    EvData, 8'h86);

        // Release (1,2).
        pressed = 16'h0000;
        wait_frame();
        wait_frame();
        check("rel_f2_fifo", fifo.size(), 1);
        check("rel_f2_keys", KeysDown, 16'h0040);
        wait_frame();
        check("rel_fifo_n", fifo.size(), 2);
        check("rel_data",   fifo[1], 8'h06);
        check("rel_keys",   KeysDown, 16'h0000);

        // Keys 0 and 15 together: two events in one frame, row-major order.
        pressed = 16'h8001;
        wait_frame();
        wait_frame();
        check("pair_f2_fifo", fifo.size(), 2);
        wait_frame();
        check("pair_fifo_n",  fifo.size(), 4);
        check("pair_first",   fifo[2], 8'h80);
        check("pair_second",  fifo[3], 8'h8F);
        check("pair_gap_ge2", (last_gap >= 2), 1);
        check("pair_width_a", wr_width[2], 2);
        check("pair_width_b", wr_width[3], 2);
        check("pair_keys",    KeysDown, 16'h8001);

        // Release both.
        pressed = 16'h0000;
        wait_frame();
        wait_frame();
        wait_frame();
        check("relpair_fifo_n", fifo.size(), 6);
        check("relpair_first",  fifo[4], 8'h00);
        check("relpair_second", fifo[5], 8'h0F);
        check("relpair_keys",   KeysDown, 16'h0000);

        // Reset during the first EMIT cycle of key (1,1).
        pressed = 16'h0020;
        wait_frame();
        wait_frame();
        base = fifo.size();
        seen = 1'b0;
        for (int n = 0; n < 300 && !seen; n++) begin
            @(posedge clk);
            #1;
            if (EvWr) seen = 1'b1;
        end
        check("midemit_rise", seen, 1);
        rst = 1'b1;
        #1;
        check("midemit_evwr", EvWr, 0);
        check("midemit_keys", KeysDown, 16'h0000);
        check("midemit_busy", Busy, 0);
        check("midemit_row",  Row, 4'hF);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("midemit_no_write", fifo.size(), base);

        // Held key re-reports after three fresh frames.
        wait_frame();
        wait_frame();
        check("rereport_f2_fifo", fifo.size(), base);
        wait_frame();
        check("rereport_fifo_n", fifo.size(), base + 1);
        check("rereport_data",   fifo[base], 8'h85);
        check("rereport_keys",   KeysDown, 16'h0020);

        check("evdata_stable", unstable, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
